dd_rom_loader: RTL and testbench
================================

DD_ROM_LOADER -- requirements
Module: dd_rom_loader

Interface
REQ-001 SHALL have parameter EXPECTED_LEN, default 17'h10000, the number of bytes a complete index-0 ROM download must deliver.
REQ-002 SHALL have parameter ROM_INDEX, default 8'h00, the ioctl_index value that selects the game ROM set.
REQ-003 clk_sys  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  reset is synchronous and active-high.
REQ-005 ioctl_download  in  1  HPS download active.
REQ-006 ioctl_wr  in  1  one-cycle byte-valid strobe from HPS.
REQ-007 ioctl_index  in  8  download target index.
REQ-008 ioctl_addr  in  25  byte address of ioctl_dout.
REQ-009 ioctl_dout  in  8  download byte.
REQ-010 rom_wr  out  1  one-cycle write strobe to game core ROM port (ROMEN).
REQ-011 rom_addr  out  16  ROM write address (ROMAD).
REQ-012 rom_dout  out  8  ROM write data (ROMDT).
REQ-013 core_reset  out  1  hold-in-reset request to game core; high unless state DONE.
REQ-014 load_done  out  1  high only in state DONE.
REQ-015 load_err  out  1  high only in state ERR.
REQ-016 byte_cnt  out  17  bytes accepted in the current download.
REQ-017 checksum  out  8  modulo-256 sum of bytes accepted in the current download.

Function
REQ-018 Qualified write (qwr) SHALL be ioctl_wr & ioctl_download & (ioctl_index == ROM_INDEX).
REQ-019 States SHALL be IDLE, LOAD, VERIFY, DONE, ERR.
REQ-020 IDLE->LOAD, DONE->LOAD and ERR->LOAD SHALL occur when ioctl_download=1 and ioctl_index=ROM_INDEX; entering LOAD clears byte_cnt, checksum and the sticky fault flag.
REQ-021 Downloads with ioctl_index != ROM_INDEX SHALL cause no state change, no rom_wr and no counter update.
REQ-022 In LOAD, on qwr with ioctl_addr[24:16]==0, the block SHALL register rom_addr=ioctl_addr[15:0] and rom_dout=ioctl_dout and pulse rom_wr high for exactly the next cycle (latency 1).
REQ-023 In LOAD, each accepted write SHALL increment byte_cnt by 1 and add ioctl_dout to checksum, wrapping mod 256.
REQ-024 In LOAD, a qwr whose ioctl_addr[15:0] != byte_cnt[15:0] SHALL set the sticky fault flag; the byte is still written and counted.
REQ-025 In LOAD, a qwr with ioctl_addr[24:16]!=0 SHALL NOT pulse rom_wr or update counters, and SHALL set the fault flag.
REQ-026 byte_cnt SHALL saturate at 17'h1FFFF.
REQ-027 A qwr in the same cycle that ioctl_download is sampled low SHALL NOT occur by definition of qwr; a qwr in the last cycle download is high SHALL be fully accepted before LOAD->VERIFY.
REQ-028 LOAD->VERIFY SHALL occur on the first cycle ioctl_download is sampled 0.
REQ-029 VERIFY SHALL last exactly one cycle: ->DONE if fault flag=0 and byte_cnt==EXPECTED_LEN, else ->ERR.
REQ-030 DONE and ERR SHALL hold until a new matching download starts or reset.
REQ-031 core_reset, load_done and load_err SHALL be registered decodes of the current state, with no combinational path from any input.
REQ-032 byte_cnt and checksum SHALL remain stable in VERIFY, DONE and ERR.

Reset
REQ-033 While reset=1 at a clock edge, the block SHALL enter IDLE, with rom_wr=0, rom_addr=0, rom_dout=0, byte_cnt=0, checksum=0, fault=0, core_reset=1, load_done=0 and load_err=0.
REQ-034 Reset during LOAD SHALL abort the load; a further download is required to reach DONE.

Verification
REQ-035 Reset, then index 0 download of 65536 sequential bytes with value addr[7:0] -> 65536 rom_wr pulses each one cycle after qwr; byte_cnt=17'h10000; checksum=8'h00; the cycle after download falls is VERIFY, then DONE; core_reset=0.
REQ-036 Same stream with the byte at address 0x1234 skipped (addr jumps 0x1233->0x1235) -> fault set, state ERR, load_err=1, core_reset=1.
REQ-037 Download of only 0x8000 bytes -> ERR with byte_cnt=17'h08000.
REQ-038 From DONE, index 1 download with 11 writes -> no rom_wr, state stays DONE, byte_cnt unchanged.
REQ-039 Reset asserted at byte 0x4000 of a load -> IDLE next cycle, byte_cnt=0, rom_wr=0; then a full reload -> DONE.
REQ-040 A qwr with ioctl_addr=25'h010000 -> no rom_wr and ERR after download ends.

Source files
------------

// File: rtl/dd_rom_loader.sv
// dd_rom_loader: captures an HPS ioctl download into the game core's ROM
// write port, tracks byte count and checksum, and holds the core in reset
// until a complete, gap-free ROM image has arrived.
module dd_rom_loader #(
  parameter logic [16:0] EXPECTED_LEN = 17'h10000,
  parameter logic [7:0]  ROM_INDEX    = 8'h00
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        rom_wr,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_dout,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_err,
  output logic [16:0] byte_cnt,
  output logic [7:0]  checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] CNT_MAX = 17'h1FFFF;

  state_t      state_q, state_d;
  logic        rom_wr_q, rom_wr_d;
  logic [15:0] rom_addr_q, rom_addr_d;
  logic [7:0]  rom_dout_q, rom_dout_d;
  logic [16:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  checksum_q, checksum_d;
  logic        fault_q, fault_d;
  logic        core_reset_q, core_reset_d;
  logic        load_done_q, load_done_d;
  logic        load_err_q, load_err_d;

  logic index_match;
  logic start_load;
  logic qwr;
  logic addr_in_rom;

  assign index_match = (ioctl_index == ROM_INDEX);
  assign start_load  = ioctl_download & index_match;
  assign qwr         = ioctl_wr & ioctl_download & index_match;
  assign addr_in_rom = (ioctl_addr[24:16] == 9'd0);

  // Next-state and next-output computation for the whole loader.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    rom_wr_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    rom_dout_d = rom_dout_q;
    byte_cnt_d = byte_cnt_q;
    checksum_d = checksum_q;
    fault_d    = fault_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        // A new ROM download always restarts accounting from scratch.
        if (start_load) begin
          state_d    = S_LOAD;
          byte_cnt_d = '0;
          checksum_d = '0;
          fault_d    = 1'b0;
        end
      end
      S_LOAD: begin
        if (qwr) begin
          if (addr_in_rom) begin
            rom_wr_d   = 1'b1;
            rom_addr_d = ioctl_addr[15:0];
            rom_dout_d = ioctl_dout;
            checksum_d = checksum_q + ioctl_dout;
            if (byte_cnt_q != CNT_MAX) begin
              byte_cnt_d = byte_cnt_q + 17'd1;
            end
            // Out-of-order or skipped bytes are still written but poison the load.
            if (ioctl_addr[15:0] != byte_cnt_q[15:0]) begin
              fault_d = 1'b1;
            end
          end else begin
            // Bytes beyond the 64 KiB ROM window are dropped and poison the load.
            fault_d = 1'b1;
          end
        end
        if (!ioctl_download) begin
          state_d = S_VERIFY;
        end
      end
      S_VERIFY: begin
        state_d = (!fault_q && (byte_cnt_q == EXPECTED_LEN)) ? S_DONE : S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are decoded from the next state so that, once registered,
    // they line up with the current state and carry no input-to-output path.
    core_reset_d = (state_d != S_DONE);
    load_done_d  = (state_d == S_DONE);
    load_err_d   = (state_d == S_ERR);
  end

  // State and registered outputs; synchronous reset returns to IDLE.
  always_ff @(posedge clk_sys) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= S_IDLE;
      rom_wr_q     <= 1'b0;
      rom_addr_q   <= '0;
      rom_dout_q   <= '0;
      byte_cnt_q   <= '0;
      checksum_q   <= '0;
      fault_q      <= 1'b0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rom_wr_q     <= rom_wr_d;
      rom_addr_q   <= rom_addr_d;
      rom_dout_q   <= rom_dout_d;
      byte_cnt_q   <= byte_cnt_d;
      checksum_q   <= checksum_d;
      fault_q      <= fault_d;
      core_reset_q <= core_reset_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  assign rom_wr     = rom_wr_q;
  assign rom_addr   = rom_addr_q;
  assign rom_dout   = rom_dout_q;
  assign core_reset = core_reset_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign byte_cnt   = byte_cnt_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_dd_rom_loader.sv
// Self-checking bench for dd_rom_loader: randomized download streams are
// scored against a byte-level reference model of the loader's rules.
module tb_dd_rom_loader;

  // A 4 KiB image keeps several complete downloads within a short run.
  localparam logic [16:0] EXP_LEN = 17'h01000;
  localparam logic [7:0]  ROM_IDX = 8'h00;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'h00;
  logic        rom_wr;
  logic [15:0] rom_addr;
  logic [7:0]  rom_dout;
  logic        core_reset;
  logic        load_done;
  logic        load_err;
  logic [16:0] byte_cnt;
  logic [7:0]  checksum;

  dd_rom_loader #(
    .EXPECTED_LEN(EXP_LEN),
    .ROM_INDEX   (ROM_IDX)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_index   (ioctl_index),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .rom_wr        (rom_wr),
    .rom_addr      (rom_addr),
    .rom_dout      (rom_dout),
    .core_reset    (core_reset),
    .load_done     (load_done),
    .load_err      (load_err),
    .byte_cnt      (byte_cnt),
    .checksum      (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [15:0] addr;
    logic [7:0]  data;
  } rom_wr_t;

  rom_wr_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what the loader should report for the current download.
  int unsigned m_cnt = 0;
  logic [7:0]  m_sum = 8'h00;
  bit          m_fault = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  bit          dl_match = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ROM write port scoreboard: each pulse must match the oldest expected write
  // in address, data and the exact cycle it was due.
  always @(negedge clk_sys) begin
    if (rom_wr) begin
      if (exp_q.size() == 0) begin
        check("rom_wr_extra", 64'(rom_wr), 64'd0);
      end else begin : pop_exp
        rom_wr_t e;
        e = exp_q.pop_front();
        check("rom_wr", {8'd0, cyc, rom_addr, rom_dout}, {8'd0, e.cyc, e.addr, e.data});
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      check("rom_wr_missing", 64'(rom_wr), 64'd1);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_load_done"},  64'(load_done),  64'(m_done));
    check({tag, "_load_err"},   64'(load_err),   64'(m_err));
    check({tag, "_core_reset"}, 64'(core_reset), 64'(!m_done));
    check({tag, "_byte_cnt"},   64'(byte_cnt),   64'(m_cnt));
    check({tag, "_checksum"},   64'(checksum),   64'(m_sum));
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    dl_match       = (idx == ROM_IDX);
    if (dl_match) begin
      m_cnt   = 0;
      m_sum   = 8'h00;
      m_fault = 1'b0;
    end
    tick();
  endtask

  task automatic wr(input logic [24:0] addr, input logic [7:0] data, input bit gaps);
    rom_wr_t e;
    ioctl_wr   = 1'b1;
    ioctl_addr = addr;
    ioctl_dout = data;
    if (dl_match) begin
      if (addr[24:16] != 9'd0) begin
        m_fault = 1'b1;
      end else begin
        e.cyc  = cyc + 1;
        e.addr = addr[15:0];
        e.data = data;
        exp_q.push_back(e);
        if (addr[15:0] != m_cnt[15:0]) m_fault = 1'b1;
        if (m_cnt < 32'h1FFFF) m_cnt++;
        m_sum = m_sum + data;
      end
    end
    tick();
    ioctl_wr = 1'b0;
    if (gaps && $urandom_range(3) == 0) repeat ($urandom_range(2, 1)) tick();
  endtask

  task automatic end_dl(input string tag);
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    tick();
    if (dl_match) begin
      // First cycle after download falls is the single verify cycle.
      check({tag, "_verify_done"},  64'(load_done),  64'd0);
      check({tag, "_verify_err"},   64'(load_err),   64'd0);
      check({tag, "_verify_creset"}, 64'(core_reset), 64'd1);
      m_done = !m_fault && (m_cnt == 32'(EXP_LEN));
      m_err  = !m_done;
    end
    tick();
    tick();
    check_state(tag);
    check({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic full_dl(input string tag, input int n, input int skip, input bit rnd_data);
    start_dl(ROM_IDX);
    for (int a = 0; a < n; a++) begin
      if (a != skip) wr(25'(a), rnd_data ? 8'($urandom) : 8'(a), 1'b1);
    end
    end_dl(tag);
  endtask

  initial begin
    // Reset values.
    reset = 1'b1;
    repeat (3) tick();
    check("reset_rom_wr",   64'(rom_wr),   64'd0);
    check("reset_rom_addr", 64'(rom_addr), 64'd0);
    check("reset_rom_dout", 64'(rom_dout), 64'd0);
    check_state("reset");
    reset = 1'b0;
    tick();

    // Complete sequential image, data = low address byte: sums to zero.
    full_dl("full_seq", int'(EXP_LEN), -1, 1'b0);
    check("full_seq_sum_zero", 64'(checksum), 64'd0);

    // Foreign-index download must leave the completed load untouched.
    start_dl(8'h01);
    repeat (11) wr(25'($urandom_range(255)), 8'($urandom), 1'b1);
    end_dl("foreign");

    // One byte skipped mid-stream.
    full_dl("skip", int'(EXP_LEN), 'h123, 1'b1);

    // Short image.
    full_dl("short", 'h800, -1, 1'b1);

    // Good image again from ERR; counters must restart.
    full_dl("reload", int'(EXP_LEN), -1, 1'b1);

    // Reset in the middle of a load aborts it.
    start_dl(ROM_IDX);
    for (int a = 0; a < 'h400; a++) wr(25'(a), 8'($urandom), 1'b1);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h400;
    ioctl_dout = 8'h5A;
    reset      = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    check("abort_rom_wr",     64'(rom_wr),     64'd0);
    check("abort_byte_cnt",   64'(byte_cnt),   64'd0);
    check("abort_core_reset", 64'(core_reset), 64'd1);
    check("abort_load_done",  64'(load_done),  64'd0);
    ioctl_download = 1'b0;
    reset   = 1'b0;
    m_cnt   = 0;
    m_sum   = 8'h00;
    m_fault = 1'b0;
    m_done  = 1'b0;
    m_err   = 1'b0;
    tick();
    tick();
    check_state("abort_idle");
    full_dl("after_abort", int'(EXP_LEN), -1, 1'b1);

    // A write above the 64 KiB window is dropped but fails the load.
    start_dl(ROM_IDX);
    for (int a = 0; a < int'(EXP_LEN); a++) begin
      if (a == 'h200) wr(25'h010000, 8'hA5, 1'b0);
      wr(25'(a), 8'($urandom), 1'b1);
    end
    end_dl("out_of_window");

    // Short random downloads with occasional address jumps and foreign index.
    repeat (6) begin
      int n;
      int unsigned a;
      n = $urandom_range(200, 1);
      a = 0;
      start_dl(($urandom_range(3) == 0) ? 8'h02 : ROM_IDX);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(15) == 0) a = a + $urandom_range(3, 1);
        wr(25'(a), 8'($urandom), 1'b1);
        a++;
      end
      end_dl("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
